// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a 1-cycle-latency BRAM FIFO into a valid/ready stream via a 3-entry skid buffer; FIFO_READER_CNT_EN adds words_o.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rd_en_o,
    input  logic [WIDTH-1:0]     fifo_rd_data_i,
    input  logic                 flush_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [WIDTH-1:0]     m_data_o
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] words_o
`endif
);
    logic [1:0]       cnt, wr_ptr, rd_ptr;
    logic             inflight, xfer;
    logic [2:0]       occ, occ_n;
    logic [WIDTH-1:0] buf_q [3];
    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction
    always_comb begin
        occ          = {1'b0, cnt} + {2'b0, inflight};
        xfer         = m_valid_o && m_ready_i;
        occ_n        = occ - {2'b0, xfer};
        fifo_rd_en_o = rst_ni && !fifo_empty_i && !flush_i && (occ < 3'd3);
        m_data_o     = buf_q[rd_ptr];
    end
    // occupied slots plus the word in flight never exceed the 3 buffer entries
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt       <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            m_valid_o <= 1'b0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else if (flush_i) begin
            cnt       <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            m_valid_o <= 1'b0;
        end else begin
            inflight  <= fifo_rd_en_o;
            cnt       <= occ_n[1:0];
            m_valid_o <= occ_n != 3'd0;
            if (inflight) begin
                buf_q[wr_ptr] <= fifo_rd_data_i;
                wr_ptr        <= wrap_inc(wr_ptr);
            end
            if (xfer) rd_ptr <= wrap_inc(rd_ptr);
        end
    end
`ifdef FIFO_READER_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) words_o <= '0;
        else if (xfer) words_o <= words_o + CNT_WIDTH'(1);
    end
`endif
    ap_occ: assert property (@(posedge clk_i) disable iff (!rst_ni) occ <= 3'd3 && CNT_WIDTH > 0);
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: FIFO model + scoreboard of popped words checked against the output stream.
module tb_fifo_stream_reader;
    localparam int W = 8;
    logic         clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, m_ready_i = 1'b0;
    logic         fifo_rd_en_o, m_valid_o, fifo_empty_i;
    logic [W-1:0] fifo_rd_data_i = '0, m_data_o;
`ifdef FIFO_READER_CNT_EN
    logic [15:0]  words_o;
`endif
    logic [W-1:0] fmem [1024];
    int           wp = 0, rp = 0;
    logic [W-1:0] exp_q [$];
    int           checks = 0, errors = 0, n_pops = 0, n_xfer = 0;
    bit           pop_pend = 1'b0;

    assign fifo_empty_i = (wp == rp);
    always #5 clk_i = ~clk_i;

    fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o),
        .fifo_rd_data_i(fifo_rd_data_i), .flush_i(flush_i), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_data_o(m_data_o)
`ifdef FIFO_READER_CNT_EN
        , .words_o(words_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        fmem[wp] = d;
        wp++;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !m_valid_o; i++) @(negedge clk_i);
        chk("valid_timeout", m_valid_o, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && !(wp == rp && exp_q.size() == 0 && !m_valid_o); i++) @(negedge clk_i);
        chk("drain_timeout", (wp == rp && exp_q.size() == 0 && !m_valid_o), 1);
    endtask

    // FIFO model: one-cycle read latency, contents untouched by the reader's flush/reset
    always @(posedge clk_i) begin
        if (pop_pend && rst_ni) begin
            fifo_rd_data_i <= fmem[rp];
            rp <= rp + 1;
        end
    end

    // monitor: popped words enter the scoreboard, delivered words leave it in order
    always @(negedge clk_i) begin
        pop_pend = rst_ni && fifo_rd_en_o && !fifo_empty_i;
        if (rst_ni) begin
            chk("rd_en_while_empty", fifo_rd_en_o && fifo_empty_i, 0);
            if (m_valid_o && m_ready_i) begin
                n_xfer++;
                if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
                else chk("stream_data", m_data_o, exp_q.pop_front());
            end
            if (flush_i) exp_q.delete();
            if (pop_pend) begin
                n_pops++;
                exp_q.push_back(fmem[rp]);
            end
        end
    end

    initial begin
        int p0, x0, pushed;
        fmem[0] = 8'h11;
        wp = 1;
        m_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_rd_en", fifo_rd_en_o, 0);
`ifdef FIFO_READER_CNT_EN
        chk("rst_words", words_o, 0);
`endif
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("lat_rd_en_c0", fifo_rd_en_o, 1);
        chk("lat_valid_c0", m_valid_o, 0);
        @(negedge clk_i);
        chk("lat_valid_c1", m_valid_o, 0);
        @(negedge clk_i);
        chk("lat_valid_c2", m_valid_o, 1);
        chk("lat_data_c2", m_data_o, 8'h11);
        @(negedge clk_i);
        chk("lat_valid_c3", m_valid_o, 0);

        step();
        for (int i = 0; i < 64; i++) push(W'(i));
        @(negedge clk_i);
        wait_valid();
        for (int i = 0; i < 64; i++) begin
            chk("stream_valid", m_valid_o, 1);
            chk("stream_order", m_data_o, i);
            @(negedge clk_i);
        end
        chk("stream_end", m_valid_o, 0);

        step();
        m_ready_i = 1'b0;
        p0 = n_pops;
        for (int i = 0; i < 10; i++) push(W'(8'h80 + i));
        repeat (8) @(negedge clk_i);
        chk("bp_pops", n_pops - p0, 3);
        chk("bp_rd_en", fifo_rd_en_o, 0);
        chk("bp_valid", m_valid_o, 1);
        chk("bp_hold", m_data_o, 8'h80);
        repeat (3) @(negedge clk_i);
        chk("bp_hold2", m_data_o, 8'h80);
        step();
        x0 = n_xfer;
        m_ready_i = 1'b1;
        drain();
        chk("bp_delivered", n_xfer - x0, 10);

        step();
        for (int i = 0; i < 20; i++) push(W'(8'h40 + i));
        repeat (5) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_async_valid", m_valid_o, 0);
        chk("rst_async_rd_en", fifo_rd_en_o, 0);
`ifdef FIFO_READER_CNT_EN
        chk("rst_async_words", words_o, 0);
`endif
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_release_valid", m_valid_o, 0);
        drain();

        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
`ifdef FIFO_READER_CNT_EN
        chk("rand_words_start", words_o, 0);
`endif
        x0 = n_xfer;
        pushed = 0;
        for (int c = 0; c < 5000 && n_xfer - x0 < 200; c++) begin
            step();
            m_ready_i = 1'($urandom_range(0, 1));
            if (pushed < 200 && $urandom_range(0, 3) != 0) begin
                push(W'($urandom));
                pushed++;
            end
        end
        chk("rand_delivered", n_xfer - x0, 200);
        m_ready_i = 1'b1;
        drain();
`ifdef FIFO_READER_CNT_EN
        chk("rand_words", words_o, 200);
`endif

        step();
        m_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push(W'(8'hA0 + i));
        repeat (3) step();
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flush_rd_en", fifo_rd_en_o, 0);
        step();
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_valid", m_valid_o, 0);
        step();
        m_ready_i = 1'b1;
        @(negedge clk_i);
        wait_valid();
        chk("flush_resume", m_data_o, 8'hA3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
